// File: rtl/text_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : text_pkg
//  Purpose  : Shared types and constants for the text-mode renderer: the cell
//             word layout, the 8-entry colour palette, the supported glyph
//             codes and their 16x16 bitmaps (row-major, MSB = leftmost pixel).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package text_pkg;

    // One character cell as stored in the buffer: {color[2:0], code[6:0]}
    typedef struct packed {
        logic [2:0] color;
        logic [6:0] code;
    } cell_t;

    localparam logic [6:0] c_CODE_SPACE  = 7'h20;
    localparam logic [6:0] c_CODE_PCT    = 7'h25;
    localparam logic [6:0] c_CODE_STAR   = 7'h2A;
    localparam logic [6:0] c_CODE_PLUS   = 7'h2B;
    localparam logic [6:0] c_CODE_MINUS  = 7'h2D;
    localparam logic [6:0] c_CODE_SLASH  = 7'h2F;
    localparam logic [6:0] c_CODE_DIGIT0 = 7'h30;
    localparam logic [6:0] c_CODE_DIGIT9 = 7'h39;
    localparam logic [6:0] c_CODE_EQUAL  = 7'h3D;

    // Word written by the clear engine: space in palette colour 0
    localparam cell_t c_BLANK_CELL = '{color: 3'd0, code: c_CODE_SPACE};

    // 24-bit RGB palette, index 0..7
    localparam logic [0:7][23:0] c_PALETTE = {
        24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080
    };

    // Digits '0'..'9', indexed by the low nibble of the code
    localparam logic [0:9][0:15][0:15] c_GLYPH_DIGITS = {
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h300C, 16'h301C, 16'h303C, 16'h307C, 16'h30EC,
         16'h31CC, 16'h338C, 16'h370C, 16'h3E0C, 16'h3C0C, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h0180, 16'h0380, 16'h0780, 16'h0D80, 16'h0180, 16'h0180, 16'h0180,
         16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h1FF8, 16'h1FF8, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h000C, 16'h000C, 16'h000C, 16'h3FFC, 16'h3FFC,
         16'h3000, 16'h3000, 16'h3000, 16'h3000, 16'h3000, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h000C, 16'h000C, 16'h000C, 16'h0FFC, 16'h0FFC,
         16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h3FFC, 16'h3FFC,
         16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h3000, 16'h3000, 16'h3000, 16'h3FFC, 16'h3FFC,
         16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h3000, 16'h3000, 16'h3000, 16'h3FFC, 16'h3FFC,
         16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h000C, 16'h0018, 16'h0030, 16'h0060, 16'h00C0,
         16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h300C, 16'h300C, 16'h300C, 16'h3FFC, 16'h3FFC,
         16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h300C, 16'h3FFC, 16'h3FFC, 16'h0000},
        {16'h0000, 16'h3FFC, 16'h3FFC, 16'h300C, 16'h300C, 16'h300C, 16'h3FFC, 16'h3FFC,
         16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h000C, 16'h3FFC, 16'h3FFC, 16'h0000}
    };

    localparam logic [0:15][0:15] c_GLYPH_PLUS = {
        16'h0000, 16'h0000, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h3FFC,
        16'h3FFC, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0000, 16'h0000};
    localparam logic [0:15][0:15] c_GLYPH_MINUS = {
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFC,
        16'h3FFC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [0:15][0:15] c_GLYPH_STAR = {
        16'h0000, 16'h0000, 16'h0180, 16'h318C, 16'h1998, 16'h0DB0, 16'h07E0, 16'h3FFC,
        16'h3FFC, 16'h07E0, 16'h0DB0, 16'h1998, 16'h318C, 16'h0180, 16'h0000, 16'h0000};
    localparam logic [0:15][0:15] c_GLYPH_SLASH = {
        16'h0003, 16'h0006, 16'h000C, 16'h0018, 16'h0030, 16'h0060, 16'h00C0, 16'h0180,
        16'h0300, 16'h0600, 16'h0C00, 16'h1800, 16'h3000, 16'h6000, 16'hC000, 16'h0000};
    localparam logic [0:15][0:15] c_GLYPH_PCT = {
        16'h0000, 16'h3C03, 16'h3C06, 16'h3C0C, 16'h3C18, 16'h0030, 16'h0060, 16'h00C0,
        16'h0180, 16'h0300, 16'h0600, 16'h0C3C, 16'h183C, 16'h303C, 16'h603C, 16'h0000};
    localparam logic [0:15][0:15] c_GLYPH_EQUAL = {
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFC, 16'h3FFC, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h3FFC, 16'h3FFC, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

endpackage
`default_nettype wire

// File: rtl/text_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : text_renderer_if
//  Purpose  : Character-write and clear-control bundle of the text renderer.
//  Signals  : wr_valid/wr_ready handshake, wr_col/wr_row target cell,
//             wr_char ASCII code, wr_color palette index,
//             clr_start clear request pulse, busy clear in progress.
//  Modports : master (writer side), slave (renderer side)
//  Revision : 1.0  initial release
// ============================================================================
interface text_renderer_if #(
    parameter int COLS = 40,
    parameter int ROWS = 30
);
    localparam int c_COL_W = $clog2(COLS);
    localparam int c_ROW_W = $clog2(ROWS);

    logic               wr_valid;
    logic               wr_ready;
    logic [c_COL_W-1:0] wr_col;
    logic [c_ROW_W-1:0] wr_row;
    logic [6:0]         wr_char;
    logic [2:0]         wr_color;
    logic               clr_start;
    logic               busy;

    modport master (
        output wr_valid, wr_col, wr_row, wr_char, wr_color, clr_start,
        input  wr_ready, busy
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_char, wr_color, clr_start,
        output wr_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/text_renderer_glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_rom
//  Purpose  : Combinational glyph lookup: returns the bitmap bit of a 16x16
//             glyph at (gx, gy). Space and unsupported codes return 0.
//  Ports    : i_code  7-bit ASCII code
//             i_gx    glyph column 0..15 (0 = leftmost)
//             i_gy    glyph row 0..15 (0 = top)
//             o_pix   glyph pixel
//  Revision : 1.0  initial release
// ============================================================================
module glyph_rom
    import text_pkg::*;
(
    input  logic [6:0] i_code,
    input  logic [3:0] i_gx,
    input  logic [3:0] i_gy,
    output logic       o_pix
);

    logic [0:15][0:15] w_bitmap;

    always_comb begin
        w_bitmap = '0;
        if (i_code >= c_CODE_DIGIT0 && i_code <= c_CODE_DIGIT9) begin
            w_bitmap = c_GLYPH_DIGITS[i_code[3:0]];
        end else begin
            case (i_code)
                c_CODE_PLUS:  w_bitmap = c_GLYPH_PLUS;
                c_CODE_MINUS: w_bitmap = c_GLYPH_MINUS;
                c_CODE_STAR:  w_bitmap = c_GLYPH_STAR;
                c_CODE_SLASH: w_bitmap = c_GLYPH_SLASH;
                c_CODE_PCT:   w_bitmap = c_GLYPH_PCT;
                c_CODE_EQUAL: w_bitmap = c_GLYPH_EQUAL;
                default:      w_bitmap = '0;
            endcase
        end
    end

    assign o_pix = w_bitmap[i_gy][i_gx];

endmodule
`default_nettype wire

// File: rtl/text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : text_renderer
//  Purpose  : Text-mode pixel renderer. Holds a COLS x ROWS character buffer
//             (dual-port RAM, sync read) with a write port, a clear engine and
//             a blinking cursor; renders each cell as a 16x16 glyph scaled by
//             SCALE in one of 8 colours. Fixed 3-cycle pixel pipeline.
//  Ports    : pix_clk, rst_n (sync, active-low)
//             i_x, i_y, i_de, i_frame     video timing inputs
//             bus (slave)                 write handshake / clear control
//             cursor_en, cursor_col/row   cursor control
//             o_red, o_green, o_blue, o_de  pixel output (3 cycles after input)
//  Revision : 1.0  initial release
// ============================================================================
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int SCALE        = 1,
    parameter int COORD_W      = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     pix_clk,
    input  logic                     rst_n,
    input  logic [COORD_W-1:0]       i_x,
    input  logic [COORD_W-1:0]       i_y,
    input  logic                     i_de,
    input  logic                     i_frame,
    text_renderer_if.slave           bus,
    input  logic                     cursor_en,
    input  logic [$clog2(COLS)-1:0]  cursor_col,
    input  logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic [7:0]               o_red,
    output logic [7:0]               o_green,
    output logic [7:0]               o_blue,
    output logic                     o_de
);

    localparam int c_COL_W   = $clog2(COLS);
    localparam int c_ROW_W   = $clog2(ROWS);
    localparam int c_DEPTH   = COLS * ROWS;
    localparam int c_ADDR_W  = $clog2(c_DEPTH);
    localparam int c_SHIFT   = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int c_FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_DEPTH - 1);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_busy;
    logic                w_clr_we;
    logic [c_ADDR_W-1:0] r_clr_addr;
    logic                r_wr_ready;

    always_ff @(posedge pix_clk) begin
        if (!rst_n) r_state <= S_CLEAR;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.clr_start) w_state_next = S_CLEAR;
            S_CLEAR: if (r_clr_addr == c_LAST_ADDR) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Wraps back to 0 on the last address, so a later clear starts at 0.
    always_ff @(posedge pix_clk) begin
        if (!rst_n)        r_clr_addr <= '0;
        else if (w_clr_we) r_clr_addr <= (r_clr_addr == c_LAST_ADDR) ? '0
                                         : r_clr_addr + c_ADDR_W'(1);
    end

    // Ready drops in the same edge busy rises (so no write can collide with
    // the clear port) and rises one cycle after busy falls.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) r_wr_ready <= 1'b0;
        else        r_wr_ready <= (r_state == S_IDLE) && (w_state_next == S_IDLE);
    end

    assign bus.busy     = w_busy;
    assign bus.wr_ready = r_wr_ready;

    // ------------------------------------------------------------------
    // Character buffer write port
    // ------------------------------------------------------------------
    logic                w_wr_in_range;
    logic                w_mem_we;
    logic [c_ADDR_W-1:0] w_mem_addr;
    cell_t               w_mem_data;
    cell_t               r_mem [c_DEPTH];

    assign w_wr_in_range = ({1'b0, bus.wr_col} < (c_COL_W + 1)'(COLS)) &&
                           ({1'b0, bus.wr_row} < (c_ROW_W + 1)'(ROWS));

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_clr_addr;
        w_mem_data = c_BLANK_CELL;
        if (w_clr_we) begin
            w_mem_we = 1'b1;
        end else if (bus.wr_valid && r_wr_ready && w_wr_in_range) begin
            w_mem_we   = 1'b1;
            w_mem_addr = c_ADDR_W'(bus.wr_row) * c_ADDR_W'(COLS) + c_ADDR_W'(bus.wr_col);
            w_mem_data = '{color: bus.wr_color, code: bus.wr_char};
        end
    end

    always_ff @(posedge pix_clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    // ------------------------------------------------------------------
    // Blink timer
    // ------------------------------------------------------------------
    logic [c_FRAME_W-1:0] r_frame_cnt;
    logic                 r_blink_phase;

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (i_frame) begin
            if (r_frame_cnt == c_FRAME_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + c_FRAME_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: cell coordinates and buffer address
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]  w_col;
    logic [COORD_W-1:0]  w_row;
    logic                w_in_range;
    logic [c_ADDR_W-1:0] w_addr;

    assign w_col      = i_x >> (4 + c_SHIFT);
    assign w_row      = i_y >> (4 + c_SHIFT);
    assign w_in_range = (w_col < COORD_W'(COLS)) && (w_row < COORD_W'(ROWS));
    assign w_addr     = c_ADDR_W'(w_row) * c_ADDR_W'(COLS) + c_ADDR_W'(w_col);

    logic                r_s1_de;
    logic                r_s1_in_range;
    logic                r_s1_cursor;
    logic [c_ADDR_W-1:0] r_s1_addr;
    logic [3:0]          r_s1_gx;
    logic [3:0]          r_s1_gy;

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            r_s1_de       <= 1'b0;
            r_s1_in_range <= 1'b0;
            r_s1_cursor   <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_gx       <= '0;
            r_s1_gy       <= '0;
        end else begin
            r_s1_de       <= i_de;
            r_s1_in_range <= w_in_range;
            r_s1_cursor   <= cursor_en && (w_col == COORD_W'(cursor_col))
                                       && (w_row == COORD_W'(cursor_row));
            // Out-of-range pixels read address 0; their result is blanked later.
            r_s1_addr     <= w_in_range ? w_addr : '0;
            r_s1_gx       <= 4'(i_x >> c_SHIFT);
            r_s1_gy       <= 4'(i_y >> c_SHIFT);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: buffer read (old word on a same-cycle write)
    // ------------------------------------------------------------------
    logic       r_s2_de;
    logic       r_s2_in_range;
    logic       r_s2_cursor;
    logic [3:0] r_s2_gx;
    logic [3:0] r_s2_gy;
    cell_t      r_s2_cell;

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            r_s2_de       <= 1'b0;
            r_s2_in_range <= 1'b0;
            r_s2_cursor   <= 1'b0;
            r_s2_gx       <= '0;
            r_s2_gy       <= '0;
            r_s2_cell     <= '0;
        end else begin
            r_s2_de       <= r_s1_de;
            r_s2_in_range <= r_s1_in_range;
            r_s2_cursor   <= r_s1_cursor;
            r_s2_gx       <= r_s1_gx;
            r_s2_gy       <= r_s1_gy;
            r_s2_cell     <= r_mem[r_s1_addr];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: glyph lookup, cursor inversion, colour and output register
    // ------------------------------------------------------------------
    logic        w_glyph_pix;
    logic        w_pix_on;
    logic [23:0] r_rgb;
    logic        r_de_out;

    glyph_rom u_glyph_rom (
        .i_code (r_s2_cell.code),
        .i_gx   (r_s2_gx),
        .i_gy   (r_s2_gy),
        .o_pix  (w_glyph_pix)
    );

    // Phase is the registered value, so a toggle lands on the next pixel.
    assign w_pix_on = w_glyph_pix ^ (r_s2_cursor && r_blink_phase);

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            r_rgb    <= '0;
            r_de_out <= 1'b0;
        end else begin
            r_rgb    <= (r_s2_de && r_s2_in_range && w_pix_on) ? c_PALETTE[r_s2_cell.color]
                                                                : 24'h000000;
            r_de_out <= r_s2_de;
        end
    end

    assign o_red   = r_rgb[23:16];
    assign o_green = r_rgb[15:8];
    assign o_blue  = r_rgb[7:0];
    assign o_de    = r_de_out;

endmodule
`default_nettype wire

// File: tb/tb_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_renderer
//  Purpose  : Directed self-checking bench for text_renderer. u_dut uses
//             SCALE=1, u_dut2 uses SCALE=2; both share clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] x1, y1, x2, y2;
    logic        de1, de2, frame1;
    logic        cur_en;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        zero_bit = 1'b0;
    logic [5:0]  zero_col = '0;
    logic [4:0]  zero_row = '0;
    logic [7:0]  red1, green1, blue1, red2, green2, blue2;
    logic        ode1, ode2;

    int n_checks = 0;
    int n_errors = 0;

    text_renderer_if #(.COLS(40), .ROWS(30)) bus1 ();
    text_renderer_if #(.COLS(40), .ROWS(30)) bus2 ();

    text_renderer #(.COLS(40), .ROWS(30), .SCALE(1), .COORD_W(12), .BLINK_FRAMES(30)) u_dut (
        .pix_clk(clk), .rst_n(rst_n), .i_x(x1), .i_y(y1), .i_de(de1), .i_frame(frame1),
        .bus(bus1), .cursor_en(cur_en), .cursor_col(cur_col), .cursor_row(cur_row),
        .o_red(red1), .o_green(green1), .o_blue(blue1), .o_de(ode1)
    );

    text_renderer #(.COLS(40), .ROWS(30), .SCALE(2), .COORD_W(12), .BLINK_FRAMES(30)) u_dut2 (
        .pix_clk(clk), .rst_n(rst_n), .i_x(x2), .i_y(y2), .i_de(de2), .i_frame(zero_bit),
        .bus(bus2), .cursor_en(zero_bit), .cursor_col(zero_col), .cursor_row(zero_row),
        .o_red(red2), .o_green(green2), .o_blue(blue2), .o_de(ode2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, wait the 3-cycle latency, compare RGB and o_de.
    task automatic probe(input int which, input int px, input int py, input logic pde,
                         input logic [23:0] exp_rgb, input string tag);
        @(negedge clk);
        if (which == 1) begin x1 = 12'(px); y1 = 12'(py); de1 = pde; end
        else            begin x2 = 12'(px); y2 = 12'(py); de2 = pde; end
        repeat (3) @(posedge clk);
        #1;
        if (which == 1) begin
            check({tag, " rgb"}, {8'h00, red1, green1, blue1}, {8'h00, exp_rgb});
            check({tag, " de"}, {31'd0, ode1}, {31'd0, pde});
        end else begin
            check({tag, " rgb"}, {8'h00, red2, green2, blue2}, {8'h00, exp_rgb});
            check({tag, " de"}, {31'd0, ode2}, {31'd0, pde});
        end
    endtask

    task automatic write_cell(input int which, input int col, input int row,
                              input logic [6:0] ch, input logic [2:0] color);
        int n;
        n = 0;
        @(negedge clk);
        while (((which == 1) ? bus1.wr_ready : bus2.wr_ready) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready timeout", 32'(n >= 3000), 32'd0);
        if (which == 1) begin
            bus1.wr_col = 6'(col); bus1.wr_row = 5'(row); bus1.wr_char = ch;
            bus1.wr_color = color; bus1.wr_valid = 1'b1;
        end else begin
            bus2.wr_col = 6'(col); bus2.wr_row = 5'(row); bus2.wr_char = ch;
            bus2.wr_color = color; bus2.wr_valid = 1'b1;
        end
        @(negedge clk);
        bus1.wr_valid = 1'b0;
        bus2.wr_valid = 1'b0;
    endtask

    task automatic pulse_frames(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk); frame1 = 1'b1;
            @(negedge clk); frame1 = 1'b0;
        end
    endtask

    task automatic wait_clear_done(input string tag);
        int n;
        n = 0;
        while (bus1.busy === 1'b1 && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 32'(n >= 5000), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen_ready;
        rst_n = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; de1 = 1'b0; de2 = 1'b0; frame1 = 1'b0;
        cur_en = 1'b0; cur_col = '0; cur_row = '0;
        bus1.wr_valid = 1'b0; bus1.wr_col = '0; bus1.wr_row = '0; bus1.wr_char = '0;
        bus1.wr_color = '0; bus1.clr_start = 1'b0;
        bus2.wr_valid = 1'b0; bus2.wr_col = '0; bus2.wr_row = '0; bus2.wr_char = '0;
        bus2.wr_color = '0; bus2.clr_start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset rgb", {8'h00, red1, green1, blue1}, 32'h0);
        check("reset o_de", {31'd0, ode1}, 32'd0);
        check("reset wr_ready", {31'd0, bus1.wr_ready}, 32'd0);
        check("reset busy", {31'd0, bus1.busy}, 32'd1);

        // Clear after reset: busy for exactly 40*30 cycles, ready one later
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus1.busy === 1'b1 && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check("init clear cycles", n, 32'd1200);
        check("ready low at busy fall", {31'd0, bus1.wr_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready after clear", {31'd0, bus1.wr_ready}, 32'd1);

        // Blank screen
        probe(1, 0, 0, 1'b1, 24'h000000, "blank 0,0");
        probe(1, 321, 237, 1'b1, 24'h000000, "blank mid");
        probe(1, 639, 479, 1'b1, 24'h000000, "blank last");

        // '1' in red at (2,1): glyph row 3 covers gx 5..8
        write_cell(1, 2, 1, 7'h31, 3'd1);
        probe(1, 39, 19, 1'b1, 24'hFF0000, "one on");
        probe(1, 34, 19, 1'b1, 24'h000000, "one off");

        // Column 40 would alias onto cell (0,1) if not discarded
        write_cell(1, 40, 0, 7'h38, 3'd2);
        probe(1, 2, 19, 1'b1, 24'h000000, "oor write discarded");

        // SCALE=2: '0' white at (0,0); (4,2)->glyph(2,1) on, (2,2)->glyph(1,1) off
        write_cell(2, 0, 0, 7'h30, 3'd0);
        probe(2, 4, 2, 1'b1, 24'hFFFFFF, "scale2 on");
        probe(2, 2, 2, 1'b1, 24'h000000, "scale2 off");

        // Screen bounds and de gating
        probe(1, 640, 0, 1'b1, 24'h000000, "col 40");
        probe(1, 0, 480, 1'b1, 24'h000000, "row 30");
        probe(1, 39, 19, 1'b0, 24'h000000, "de low");

        // Cursor blink on blank cell (0,0)
        cur_en = 1'b1; cur_col = 6'd0; cur_row = 5'd0;
        probe(1, 5, 5, 1'b1, 24'h000000, "cursor phase0");
        pulse_frames(29);
        probe(1, 5, 5, 1'b1, 24'h000000, "cursor 29 frames");
        pulse_frames(1);
        probe(1, 5, 5, 1'b1, 24'hFFFFFF, "cursor phase1");
        pulse_frames(30);
        probe(1, 5, 5, 1'b1, 24'h000000, "cursor phase0 again");

        // Cursor over the red '1': lit pixels go dark, dark ones go red
        pulse_frames(30);
        cur_col = 6'd2; cur_row = 5'd1;
        probe(1, 39, 19, 1'b1, 24'h000000, "cursor inv on");
        probe(1, 34, 19, 1'b1, 24'hFF0000, "cursor inv off");
        cur_en = 1'b0;

        // Clear with a write held pending: nothing accepted while busy
        @(negedge clk); bus1.clr_start = 1'b1;
        @(negedge clk); bus1.clr_start = 1'b0;
        check("clear busy", {31'd0, bus1.busy}, 32'd1);
        check("clear ready low", {31'd0, bus1.wr_ready}, 32'd0);
        bus1.wr_col = 6'd1; bus1.wr_row = 5'd1; bus1.wr_char = 7'h35;
        bus1.wr_color = 3'd3; bus1.wr_valid = 1'b1;
        seen_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.wr_ready !== 1'b0) seen_ready++;
        end
        check("ready during clear", seen_ready, 32'd0);
        bus1.wr_valid = 1'b0;
        wait_clear_done("clear timeout");
        probe(1, 39, 19, 1'b1, 24'h000000, "cleared one");
        probe(1, 18, 19, 1'b1, 24'h000000, "blocked write");

        // Write and clear request in the same cycle: clear wins
        write_cell(1, 3, 0, 7'h38, 3'd4);
        probe(1, 50, 3, 1'b1, 24'hFFFF00, "eight before");
        @(negedge clk);
        while (bus1.wr_ready !== 1'b1) @(negedge clk);
        bus1.wr_col = 6'd4; bus1.wr_row = 5'd0; bus1.wr_char = 7'h38;
        bus1.wr_color = 3'd4; bus1.wr_valid = 1'b1; bus1.clr_start = 1'b1;
        @(negedge clk);
        bus1.wr_valid = 1'b0; bus1.clr_start = 1'b0;
        wait_clear_done("clear2 timeout");
        probe(1, 66, 3, 1'b1, 24'h000000, "write+clear");
        probe(1, 50, 3, 1'b1, 24'h000000, "eight cleared");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_renderer.md
# text_renderer

Parametrised text-mode pixel renderer for the IO_graphics path. It sits between the video timing generator and the RGB output, holding a COLS×ROWS character buffer with a write port, an automatic clear engine and a blinking cursor. The block is the successor to the single-glyph combinational renderer. Each cell renders a 16×16 glyph, replicated SCALE times in each axis, in one of 8 palette colours on a black background. The pixel path is a fixed 3-cycle pipeline.

## Interface
- COLS, 40: text columns.
- ROWS, 30: text rows.
- SCALE, 1: pixel replication factor; must be 1, 2 or 4. Cell size is 16·SCALE pixels square.
- COORD_W, 12: width of the pixel coordinates.
- BLINK_FRAMES, 30: number of frames per cursor blink phase.

Ports:
- pix_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_x, i_y  in  COORD_W  current pixel coordinates.
- i_de  in  1  active-video enable for the current pixel.
- i_frame  in  1  one-cycle pulse at frame start.
- wr_valid  in  1  character write request.
- wr_ready  out  1  write can be accepted.
- wr_col  in  $clog2(COLS)  target column.
- wr_row  in  $clog2(ROWS)  target row.
- wr_char  in  7  ASCII code.
- wr_color  in  3  palette index.
- clr_start  in  1  one-cycle pulse requesting a buffer clear.
- busy  out  1  clear in progress.
- cursor_en  in  1  cursor display enable.
- cursor_col, cursor_row  in  same widths as wr_col, wr_row  cursor position.
- o_red, o_green, o_blue  out  8 each  pixel colour.
- o_de  out  1  i_de delayed to align with the RGB outputs.

## Operation
- The buffer holds one 10-bit word per cell, {color[2:0], char[6:0]}, at address row·COLS+col. The buffer is dual-ported: one write port and one read port.
- Write handshake:
  - A write is accepted on a cycle where wr_valid and wr_ready are both high.
  - wr_ready = !busy, registered.
  - A write with col≥COLS or row≥ROWS is accepted and discarded.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR.
  - clr_start in IDLE enters CLEAR.
  - CLEAR writes {3'd0, 7'h20} to addresses 0..COLS·ROWS−1, one address per cycle, then returns to IDLE.
  - busy is high in CLEAR.
  - clr_start is ignored while in CLEAR.
- Pixel path:
  - col = i_x >> (4+log2 SCALE), row = i_y >> (4+log2 SCALE).
  - Glyph coordinates: gx = (i_x >> log2 SCALE) mod 16, gy likewise from i_y.
  - Glyph bit index is [gy][gx], row-major, with MSB-first columns.
- Supported glyphs: codes 0x30–0x39, 0x2B, 0x2D, 0x2A, 0x2F, 0x25, 0x3D and 0x20 (space). Any other code renders blank.
- Pixel colour:
  - Pixel is on → palette[color].
  - Pixel is off → black.
  - i_de low, or col≥COLS, or row≥ROWS → black.
- Palette: 0 white FFFFFF, 1 red FF0000, 2 green 00FF00, 3 blue 0000FF, 4 yellow FFFF00, 5 cyan 00FFFF, 6 magenta FF00FF, 7 grey 808080.
- Cursor:
  - A frame counter increments on each i_frame pulse. At BLINK_FRAMES−1 it wraps to 0 and toggles blink_phase.
  - When cursor_en=1, blink_phase=1 and the cell equals (cursor_col, cursor_row), the glyph bit is inverted before colouring.

## Timing
- Pipeline latency is exactly 3 cycles from (i_x, i_y, i_de) to (RGB, o_de), with no stalls:
  - Stage 1: register coordinates and compute the address.
  - Stage 2: buffer read.
  - Stage 3: glyph lookup, colour selection and output register.
- A write to a cell in the same cycle as that cell's read returns the old word; the new word is visible from the next cycle.
- Values after reset:
  - RGB = 0, o_de = 0.
  - wr_ready = 0, busy = 1.
  - blink_phase = 0, frame counter = 0.
  - Pipeline registers are cleared.
- Clear takes COLS·ROWS cycles. wr_ready rises 1 cycle after busy falls.
- Reset asserted mid-clear restarts the clear at address 0.
- clr_start in the same cycle as an accepted write: the write lands first, and the clear then overwrites it.
- i_frame and a blink wrap coinciding with a displayed cursor pixel: the new phase applies from the next cycle.

## Structure
- Package `text_pkg` holds:
  - The palette constant array.
  - The cell-word typedef {color, char}.
  - Glyph code localparams.
  - The 16×16 glyph bitmaps as `logic [0:15][0:15]` constants.
- Sub-module `glyph_rom` is combinational, (code, gx, gy) → bit. It returns 0 for undefined codes.
- The buffer is inferred as dual-port block RAM with synchronous read.

## Test plan
- Reset release → busy high for 1200 cycles (40×30), then wr_ready=1. Every cell renders black, since space is blank.
- Write (col 2, row 1, char 0x31, color 1), then drive x=32+7, y=16+3 with de=1 → 3 cycles later RGB=FF0000. At x=32+2 → 000000.
- Set SCALE=2 and write '0' at (0,0) with color 0. Pixel (4,2), which maps to glyph (2,1), renders FFFFFF. Pixel (2,2) renders black.
- Set cursor_en=1 and cursor at (0,0), and pulse i_frame 30 times → blink_phase=1, and the blank cell at (0,0) shows palette 0 (white). After 30 more pulses it shows black.
- Pulse clr_start, then assert wr_valid during the clear → wr_ready=0 and no write is accepted. Once busy falls, all cells read back as space.
- Drive x=640 (col 40), de=1, with COLS=40 → black output. Drive de=0 → black output and o_de=0 after 3 cycles.
